// File: rtl/mips_trace_pkg.sv
// Shared defaults and the entry layout for the MIPS result trace buffer.
// The FIFO itself stores the entry as a flat {data, stamp} word.
package mips_trace_pkg;

  localparam int TRACE_DATA_W  = 32;
  localparam int TRACE_STAMP_W = 16;
  localparam int TRACE_DEPTH   = 8;
  localparam int TRACE_DROP_W  = 8;

  typedef struct packed {
    logic [TRACE_DATA_W-1:0]  data;
    logic [TRACE_STAMP_W-1:0] stamp;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a separate occupancy register.
// A push into a full FIFO is only accepted when a pop frees the head in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; memory is cleared so the head reads zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/result_trace_buffer.sv
// Watches the MIPS result bus, stamps each change with a free-running cycle count
// and queues (value, stamp) pairs for a valid/ready consumer.
module result_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DATA_W  = TRACE_DATA_W,
  parameter int STAMP_W = TRACE_STAMP_W,
  parameter int DEPTH   = TRACE_DEPTH,
  parameter int DROP_W  = TRACE_DROP_W
) (
  input  logic                    cclk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       result_in,
  input  logic                    capture_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [STAMP_W-1:0]      out_stamp,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_count
);

  logic [STAMP_W-1:0] r_stamp;
  logic [DATA_W-1:0]  r_last_val;
  logic               r_last_valid;
  logic               r_overflow;
  logic [DROP_W-1:0]  r_drop_count;

  logic                        w_cap;
  logic                        w_drop;
  logic                        w_full;
  logic                        w_empty;
  logic [DATA_W+STAMP_W-1:0]   w_head;

  // The first enabled cycle after reset captures unconditionally, even for a zero result.
  assign w_cap  = capture_en & (~r_last_valid | (result_in != r_last_val));
  assign w_drop = w_cap & w_full & ~(out_ready & ~w_empty);

  trace_fifo #(
    .WIDTH (DATA_W + STAMP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (cclk),
    .i_reset     (reset),
    .i_push      (w_cap),
    .i_push_data ({result_in, r_stamp}),
    .i_pop       (out_ready),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count),
    .o_head      (w_head)
  );

  assign out_valid  = ~w_empty;
  assign out_data   = w_head[STAMP_W +: DATA_W];
  assign out_stamp  = w_head[STAMP_W-1:0];
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  // Stamp counter, change-detect history and sticky drop accounting.
  always_ff @(posedge cclk) begin
    if (reset) begin
      r_stamp      <= {STAMP_W{1'b0}};
      r_last_val   <= {DATA_W{1'b0}};
      r_last_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= {DROP_W{1'b0}};
    end else begin
      r_stamp <= r_stamp + STAMP_W'(1);
      if (w_cap) begin
        r_last_val   <= result_in;
        r_last_valid <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != {DROP_W{1'b1}}) begin
          r_drop_count <= r_drop_count + DROP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_result_trace_buffer.sv
// Directed bench for result_trace_buffer: a default instance plus a STAMP_W=4 instance for wrap.
module tb_result_trace_buffer;

  logic        cclk;
  logic        reset;
  logic [31:0] result_in;
  logic        capture_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_stamp;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  logic        reset4;
  logic [31:0] result4;
  logic        cap4;
  logic        valid4;
  logic        ready4;
  logic [31:0] data4;
  logic [3:0]  stamp4;
  logic [3:0]  count4;
  logic        ovf4;
  logic [7:0]  drop4;

  int          total;
  int          bad;
  logic [15:0] stamp_m;
  logic [15:0] st;
  logic [15:0] fill_st [10];
  int          seq_v   [6];
  logic        seq_hit [6];

  result_trace_buffer u_dut (
    .cclk       (cclk),
    .reset      (reset),
    .result_in  (result_in),
    .capture_en (capture_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_stamp  (out_stamp),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  result_trace_buffer #(.STAMP_W(4)) u_dut4 (
    .cclk       (cclk),
    .reset      (reset4),
    .result_in  (result4),
    .capture_en (cap4),
    .out_valid  (valid4),
    .out_ready  (ready4),
    .out_data   (data4),
    .out_stamp  (stamp4),
    .fifo_count (count4),
    .overflow   (ovf4),
    .drop_count (drop4)
  );

  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, track the expected stamp of the default instance, sample #1 later.
  task automatic tick();
    @(posedge cclk);
    if (reset) stamp_m = 16'd0;
    else       stamp_m = stamp_m + 16'd1;
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    stamp_m = 16'd0;
    reset = 1'b1; result_in = 32'd0; capture_en = 1'b0; out_ready = 1'b0;
    reset4 = 1'b1; result4 = 32'd0; cap4 = 1'b0; ready4 = 1'b0;
    seq_v   = '{5, 5, 7, 7, 7, 9};
    seq_hit = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", fifo_count, 4'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", drop_count, 8'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_stamp", out_stamp, 16'd0);

    // First enabled cycle captures a zero result with stamp 0.
    reset = 1'b0; capture_en = 1'b1;
    tick();
    chk("first_valid", out_valid, 1'b1);
    chk("first_data", out_data, 32'd0);
    chk("first_stamp", out_stamp, 16'd0);
    chk("first_count", fifo_count, 4'd1);
    out_ready = 1'b1;
    tick();
    chk("first_pop_valid", out_valid, 1'b0);

    // 5,5,7,7,7,9 with ready high: only changes appear, each for one cycle.
    for (int i = 0; i < 6; i++) begin
      result_in = 32'(seq_v[i]);
      st = stamp_m;
      tick();
      chk($sformatf("seq_valid_%0d", i), out_valid, seq_hit[i]);
      if (seq_hit[i]) begin
        chk($sformatf("seq_data_%0d", i), out_data, 32'(seq_v[i]));
        chk($sformatf("seq_stamp_%0d", i), out_stamp, st);
      end
    end
    tick();
    chk("seq_drained", out_valid, 1'b0);

    // Ten distinct values with ready low: eight kept, two dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      result_in = 32'd100 + 32'(i);
      fill_st[i] = stamp_m;
      tick();
    end
    chk("fill_count", fifo_count, 4'd8);
    chk("fill_ovf", overflow, 1'b1);
    chk("fill_drop", drop_count, 8'd2);
    chk("fill_head", out_data, 32'd100);
    chk("fill_head_stamp", out_stamp, fill_st[0]);

    // Full with simultaneous push and pop: both happen, no drop.
    result_in = 32'd200; out_ready = 1'b1;
    st = stamp_m;
    tick();
    chk("fullpp_count", fifo_count, 4'd8);
    chk("fullpp_drop", drop_count, 8'd2);
    chk("fullpp_head", out_data, 32'd101);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_valid_%0d", i), out_valid, 1'b1);
      chk($sformatf("drain_data_%0d", i), out_data, (i < 7) ? 32'd101 + 32'(i) : 32'd200);
      chk($sformatf("drain_stamp_%0d", i), out_stamp, (i < 7) ? fill_st[i+1] : st);
      tick();
    end
    chk("drain_empty", out_valid, 1'b0);
    tick();
    chk("empty_pop_count", fifo_count, 4'd0);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset with five queued entries discards everything.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      result_in = 32'd300 + 32'(i);
      tick();
    end
    chk("q5_count", fifo_count, 4'd5);
    reset = 1'b1; result_in = 32'd305;
    tick();
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_count", fifo_count, 4'd0);
    chk("mrst_ovf", overflow, 1'b0);
    chk("mrst_drop", drop_count, 8'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_data", out_data, 32'd305);
    chk("post_rst_stamp", out_stamp, 16'd0);
    out_ready = 1'b1; result_in = 32'd306;
    tick();
    chk("post_rst_next_data", out_data, 32'd306);
    chk("post_rst_next_stamp", out_stamp, 16'd1);
    chk("post_rst_next_count", fifo_count, 4'd1);

    // capture_en low blocks capture.
    out_ready = 1'b0; capture_en = 1'b0; result_in = 32'd400;
    tick();
    chk("capoff_count", fifo_count, 4'd1);

    // Seven pushes fill the FIFO, then 260 drops saturate the counter.
    capture_en = 1'b1;
    for (int i = 0; i < 267; i++) begin
      result_in = 32'd1000 + 32'(i);
      tick();
    end
    chk("sat_count", fifo_count, 4'd8);
    chk("sat_drop", drop_count, 8'd255);
    chk("sat_ovf", overflow, 1'b1);

    // Stamp wrap on the 4-bit instance.
    reset4 = 1'b0; cap4 = 1'b1; ready4 = 1'b1; result4 = 32'd0;
    repeat (15) tick();
    result4 = 32'd1;
    tick();
    chk("wrap_data15", data4, 32'd1);
    chk("wrap_stamp15", stamp4, 4'd15);
    result4 = 32'd2;
    tick();
    chk("wrap_data0", data4, 32'd2);
    chk("wrap_stamp0", stamp4, 4'd0);
    result4 = 32'd3;
    tick();
    chk("wrap_stamp1", stamp4, 4'd1);
    chk("wrap_valid", valid4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
